// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl_if: byte-level receive/transmit handshake between the UART and the command controller
interface uart_cmd_ctrl_if;
  logic [7:0] rx_data, tx_data;
  logic rx_avail, rx_error, rx_ack, tx_wr, tx_busy;
  modport master(input rx_data, rx_avail, rx_error, tx_busy, output rx_ack, tx_data, tx_wr);
  modport slave(output rx_data, rx_avail, rx_error, tx_busy, input rx_ack, tx_data, tx_wr);
endinterface

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: UART command decoder that loads key/plaintext, starts the cipher core and streams back ciphertext plus status
module uart_cmd_ctrl #(
  parameter int KEY_BYTES = 48,
  parameter int BLK_BYTES = 16,
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic n_reset,
  uart_cmd_ctrl_if.master u,
  output logic [8*KEY_BYTES-1:0] key,
  output logic [8*BLK_BYTES-1:0] pt,
  output logic core_start,
  input  logic core_done,
  input  logic [8*BLK_BYTES-1:0] ct
);
  localparam int KW = 8 * KEY_BYTES;
  localparam int BW = 8 * BLK_BYTES;
  localparam int CW = $clog2(KEY_BYTES > BLK_BYTES ? KEY_BYTES : BLK_BYTES) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_PT, START, WAIT, SEND, STATUS} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [BW-1:0] sh;
  logic [7:0] st, st_n;
  logic load, rx_on, err, take, expire, last, issue;
  always_comb begin
    load = state == LOAD_KEY || state == LOAD_PT;
    rx_on = state == IDLE || load;
    err = rx_on && u.rx_error && !u.rx_ack;
    take = rx_on && u.rx_avail && !u.rx_error && !u.rx_ack;
    expire = load && tmo == TW'(TIMEOUT - 1);
    last = cnt == CW'(state == LOAD_KEY ? KEY_BYTES - 1 : BLK_BYTES - 1);
    issue = (state == SEND || state == STATUS) && !u.tx_busy && !u.tx_wr;
    state_n = state;
    st_n = st;
    case (state)
      IDLE: if (take) begin
        state_n = u.rx_data == 8'h01 ? LOAD_KEY : u.rx_data == 8'h02 ? LOAD_PT :
                  u.rx_data == 8'h03 ? START : STATUS;
        st_n = 8'hEE;
      end
      LOAD_KEY, LOAD_PT: if (err || expire) begin
        state_n = STATUS;
        st_n = 8'hEE;
      end else if (take && last) begin
        state_n = STATUS;
        st_n = 8'hA5;
      end
      START: state_n = WAIT;
      WAIT: if (core_done) state_n = SEND;
      SEND: if (issue && cnt == CW'(BLK_BYTES - 1)) begin
        state_n = STATUS;
        st_n = 8'hA5;
      end
      STATUS: if (issue) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) state <= IDLE;
    else state <= state_n;
  // cnt counts payload bytes in LOAD and transmitted bytes in SEND; any state change clears it
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      key <= '0;
      pt <= '0;
      sh <= '0;
      st <= '0;
      cnt <= '0;
      tmo <= '0;
      core_start <= 1'b0;
      u.rx_ack <= 1'b0;
      u.tx_wr <= 1'b0;
      u.tx_data <= '0;
    end else begin
      u.rx_ack <= take || err;
      u.tx_wr <= issue;
      core_start <= state == START;
      st <= st_n;
      if (issue) u.tx_data <= state == SEND ? sh[BW-1 -: 8] : st;
      if (state == WAIT && core_done) sh <= ct;
      else if (issue && state == SEND) sh <= sh << 8;
      if (take && state == LOAD_KEY) key <= {key[KW-9:0], u.rx_data};
      if (take && state == LOAD_PT) pt <= {pt[BW-9:0], u.rx_data};
      if (state_n != state) cnt <= '0;
      else if ((take && load) || (issue && state == SEND)) cnt <= cnt + 1'b1;
      tmo <= (!load || take || state_n != state) ? '0 : tmo + 1'b1;
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: randomized scoreboard bench with UART rx/tx and cipher core models
module tb_uart_cmd_ctrl;
  localparam int KB = 48;
  localparam int BB = 16;
  localparam int TO = 100;
  logic clk = 0;
  logic n_reset = 0;
  logic [8*KB-1:0] key;
  logic [8*BB-1:0] pt, ct;
  logic core_start, core_done;
  uart_cmd_ctrl_if u();
  uart_cmd_ctrl #(.KEY_BYTES(KB), .BLK_BYTES(BB), .TIMEOUT(TO)) dut (
    .clk(clk), .n_reset(n_reset), .u(u), .key(key), .pt(pt),
    .core_start(core_start), .core_done(core_done), .ct(ct)
  );
  always #5 clk = ~clk;
  typedef struct {logic [7:0] d; bit e; int gap;} rx_t;
  rx_t rx_q[$];
  logic [7:0] exp_tx[$];
  int compared = 0, mismatched = 0, cyc = 0;
  int acks = 0, items = 0, starts = 0, starts_m = 0, last_ack = 0, last_tx = 0;
  logic [8*KB-1:0] key_m = '0;
  logic [8*BB-1:0] pt_m = '0, ct_val = '0;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // UART receiver model: presents one byte (or framing error), clears on the edge ending rx_ack
  initial begin
    logic ack;
    rx_t r;
    u.rx_data = 0;
    u.rx_avail = 0;
    u.rx_error = 0;
    forever begin
      @(negedge clk);
      ack = u.rx_ack;
      @(posedge clk);
      #1;
      if (!n_reset) begin
        u.rx_avail = 0;
        u.rx_error = 0;
      end else begin
        if (ack) begin
          acks++;
          last_ack = cyc;
          u.rx_avail = 0;
          u.rx_error = 0;
        end
        if (!u.rx_avail && !u.rx_error && rx_q.size() > 0) begin
          if (rx_q[0].gap > 0) rx_q[0].gap--;
          else begin
            r = rx_q.pop_front();
            u.rx_data = r.d;
            u.rx_avail = !r.e;
            u.rx_error = r.e;
            items++;
          end
        end
      end
    end
  end
  // UART transmitter model and tx monitor
  initial begin
    int busy;
    logic prev, fire;
    busy = 0;
    prev = 0;
    u.tx_busy = 0;
    forever begin
      @(negedge clk);
      fire = u.tx_wr;
      if (fire) begin
        check("tx_wr_while_busy", 512'(u.tx_busy), 512'(0));
        check("tx_wr_back_to_back", 512'(prev), 512'(0));
        if (exp_tx.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL tx_unexpected: got %0h expected no byte", u.tx_data);
        end else check("tx_byte", 512'(u.tx_data), 512'(exp_tx.pop_front()));
        last_tx = cyc;
      end
      prev = fire;
      @(posedge clk);
      #1;
      if (!n_reset) busy = 0;
      else if (fire) busy = $urandom_range(2, 6);
      else if (busy > 0) busy--;
      u.tx_busy = busy > 0;
    end
  end
  // cipher core model: done 20 cycles after start with ct valid only in that cycle
  initial begin
    core_done = 0;
    ct = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        starts++;
        check("pt_at_start", 512'(pt), 512'(pt_m));
        repeat (20) @(posedge clk);
        #1;
        core_done = 1;
        ct = ct_val;
        @(posedge clk);
        #1;
        core_done = 0;
        ct = ~ct_val;
      end
    end
  end
  initial begin
    #800000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  task automatic push(input logic [7:0] d, input bit e, input int gap);
    rx_t r;
    r.d = d;
    r.e = e;
    r.gap = gap;
    rx_q.push_back(r);
  endtask
  task automatic drain(input int budget);
    int n = 0, idle = 0;
    while (idle < 8 && n < budget) begin
      @(posedge clk);
      n++;
      idle = (rx_q.size() == 0 && !u.rx_avail && !u.rx_error && exp_tx.size() == 0 && !u.tx_busy) ? idle + 1 : 0;
    end
    check("drain", 512'(exp_tx.size() + rx_q.size()), 512'(0));
    exp_tx.delete();
    rx_q.delete();
  endtask
  task automatic load_bytes(input bit is_key, input int n, input bit rnd, input logic [7:0] base);
    logic [7:0] b;
    push(is_key ? 8'h01 : 8'h02, 0, $urandom_range(0, 3));
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom) : base + 8'(i);
      push(b, 0, $urandom_range(0, 3));
      if (is_key) key_m = (key_m << 8) | (8*KB)'(b);
      else pt_m = (pt_m << 8) | (8*BB)'(b);
    end
  endtask
  task automatic load_frame(input bit is_key, input bit rnd, input logic [7:0] base);
    load_bytes(is_key, is_key ? KB : BB, rnd, base);
    exp_tx.push_back(8'hA5);
    drain(1500);
    check(is_key ? "key_load" : "pt_load", is_key ? 512'(key) : 512'(pt), is_key ? 512'(key_m) : 512'(pt_m));
  endtask
  task automatic start_cmd(input logic [8*BB-1:0] c);
    ct_val = c;
    push(8'h03, 0, 0);
    starts_m++;
    for (int i = BB - 1; i >= 0; i--) exp_tx.push_back(c[8*i +: 8]);
    exp_tx.push_back(8'hA5);
  endtask
  initial begin
    logic [8*BB-1:0] c;
    logic [7:0] b;
    int d, k;
    repeat (3) @(negedge clk);
    check("rst_key", 512'(key), 512'(0));
    check("rst_pt", 512'(pt), 512'(0));
    check("rst_outs", 512'({u.rx_ack, u.tx_wr, core_start, u.tx_data}), 512'(0));
    n_reset = 1;
    load_bytes(1, 10, 1, 0);
    d = 0;
    while ((rx_q.size() > 0 || acks != items) && d < 200) begin
      @(posedge clk);
      d++;
    end
    check("prereset_acks", 512'(acks), 512'(items));
    @(negedge clk);
    n_reset = 0;
    key_m = '0;
    #1;
    check("midrst_key", 512'(key), 512'(0));
    check("midrst_outs", 512'({u.rx_ack, u.tx_wr, core_start, u.tx_data}), 512'(0));
    repeat (2) @(negedge clk);
    n_reset = 1;
    load_frame(1, 0, 8'h00);
    c = '0;
    for (int i = 0; i < KB; i++) c = c;
    check("key_const", 512'(key[8*KB-1 -: 64]), 512'(64'h0001020304050607));
    load_frame(0, 0, 8'h10);
    check("pt_const", 512'(pt), 512'(128'h101112131415161718191A1B1C1D1E1F));
    for (int i = 0; i < BB; i++) c = (c << 8) | (8*BB)'(8'hF0 + 8'(i));
    start_cmd(c);
    drain(1500);
    check("one_start", 512'(starts), 512'(1));
    push(8'h7E, 0, 0);
    exp_tx.push_back(8'hEE);
    drain(300);
    check("bad_key_kept", 512'(key), 512'(key_m));
    check("bad_pt_kept", 512'(pt), 512'(pt_m));
    load_bytes(0, 5, 1, 0);
    exp_tx.push_back(8'hEE);
    drain(800);
    d = last_tx - last_ack;
    check("timeout_latency", 512'(d >= 90 && d <= 120), 512'(1));
    check("timeout_partial_pt", 512'(pt), 512'(pt_m));
    load_frame(0, 1, 0);
    load_bytes(0, 3, 1, 0);
    push(8'h00, 1, 1);
    exp_tx.push_back(8'hEE);
    drain(500);
    check("err_acks", 512'(acks), 512'(items));
    load_frame(0, 1, 0);
    c = {$urandom, $urandom, $urandom, $urandom};
    start_cmd(c);
    push(8'h7E, 0, 0);
    exp_tx.push_back(8'hEE);
    drain(1500);
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 6))
        0: load_frame(1, 1, 0);
        1: load_frame(0, 1, 0);
        2: begin
          start_cmd({$urandom, $urandom, $urandom, $urandom});
          drain(1500);
        end
        3: begin
          do b = 8'($urandom); while (b >= 8'h01 && b <= 8'h03);
          push(b, 0, 0);
          exp_tx.push_back(8'hEE);
          drain(300);
        end
        4: begin
          push(8'h00, 1, 0);
          drain(300);
        end
        5: begin
          k = $urandom_range(0, 1);
          load_bytes(k[0], $urandom_range(0, 8), 1, 0);
          push(8'h00, 1, $urandom_range(0, 3));
          exp_tx.push_back(8'hEE);
          drain(600);
        end
        default: begin
          k = $urandom_range(0, 1);
          load_bytes(k[0], $urandom_range(1, 8), 1, 0);
          exp_tx.push_back(8'hEE);
          drain(800);
        end
      endcase
      check("rand_key", 512'(key), 512'(key_m));
      check("rand_pt", 512'(pt), 512'(pt_m));
    end
    check("final_acks", 512'(acks), 512'(items));
    check("final_starts", 512'(starts), 512'(starts_m));
    check("final_tx_empty", 512'(exp_tx.size()), 512'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Host-side protocol engine on the byte interface of the 8N1 UART. It consumes the UART receive handshake (rx_data/rx_avail/rx_error/rx_ack) and drives the transmit handshake (tx_data/tx_wr/tx_busy).
- It decodes single-byte commands, shifts key and plaintext bytes into registers for the SKINNY-128-384 core, and starts the core.
- It streams the ciphertext back and answers every command with a status byte.

Parameters:
- KEY_BYTES, 48, key length in bytes; the key register is 8*KEY_BYTES bits wide.
- BLK_BYTES, 16, block length in bytes; plaintext and ciphertext are 8*BLK_BYTES bits wide.
- TIMEOUT, 1000000, maximum clk cycles allowed between payload bytes before the frame is aborted.

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte from the UART.
- rx_avail  in  1  received byte valid; held until acknowledged.
- rx_error  in  1  framing error flag; held until acknowledged.
- rx_ack  out  1  one-cycle pulse that clears rx_avail and rx_error.
- tx_data  out  8  byte to transmit.
- tx_wr  out  1  one-cycle transmit strobe.
- tx_busy  in  1  UART transmitter busy.
- key  out  8*KEY_BYTES  key register.
- pt  out  8*BLK_BYTES  plaintext register.
- core_start  out  1  one-cycle start pulse to the core.
- core_done  in  1  core finished; ct is valid in the same cycle.
- ct  in  8*BLK_BYTES  ciphertext from the core.

Behaviour:
- Reset: all outputs are 0, including key, pt, tx_data, rx_ack, tx_wr and core_start. The FSM enters IDLE and all counters clear. Asserting reset mid-frame or mid-transmit aborts immediately. A tx_wr that has not yet been issued is lost.
- RX consume rule: a byte is taken when rx_avail && !rx_ack. rx_ack pulses in the cycle after the take. The UART clears its flags at the edge ending the rx_ack cycle, so the !rx_ack gate prevents a double take.
- rx_error: whenever rx_error && !rx_ack, the controller pulses rx_ack.
  - In LOAD_KEY or LOAD_PT this aborts the frame: the status byte is 0xEE, then the FSM returns to IDLE.
  - In IDLE the error is acknowledged silently.
- TX issue rule: tx_wr pulses only when !tx_busy && !tx_wr. This covers the cycle before tx_busy rises. tx_data is stable from the tx_wr cycle until the next write.
- Commands, recognised in IDLE:
  - 0x01: go to LOAD_KEY.
  - 0x02: go to LOAD_PT.
  - 0x03: go to START.
  - Any other byte: status 0xEE, then IDLE.
- LOAD_KEY / LOAD_PT:
  - Each payload byte shifts into the LSB end of the register: reg <= {reg[W-9:0], byte}. The first byte received therefore ends up in the MSBs.
  - A byte counter starts at 0. After byte KEY_BYTES (or BLK_BYTES) the status is 0xA5 and the FSM returns to IDLE.
  - The register is updated in place; partial loads are not rolled back on abort.
- Timeout: an inter-byte counter resets on every taken byte and on entering a LOAD state. When it reaches TIMEOUT-1 in a LOAD state, the frame aborts with 0xEE.
- START: pulse core_start for 1 cycle, then go to WAIT.
- WAIT:
  - On core_done, ct is latched into an internal shift register and the FSM goes to SEND.
  - rx_avail is not consumed in WAIT; pending bytes are handled after return to IDLE.
- SEND: transmits BLK_BYTES bytes, MSB byte first, each issued under the TX rule. It then sends status 0xA5 and returns to IDLE.
- STATUS: a single byte is issued under the TX rule, then the FSM goes to IDLE.
- Command bytes are not consumed in SEND/STATUS; they are taken on return to IDLE.
- core_done outside WAIT is ignored. A second 0x03 restarts with the current pt.

Test Plan:
- Reset mid-LOAD_KEY after 10 bytes, release, then send 0x01 plus 48 bytes 0x00..0x2F → key == 0x000102…2F; one tx byte 0xA5; no stale state.
- 0x02 plus 16 bytes 0x10..0x1F, then 0x03; core model asserts core_done 20 cycles after core_start with ct=0xF0F1…FF → exactly one core_start; pt == 0x1011…1F; tx bytes F0,F1,…,FF,A5 in order.
- Byte 0x7E in IDLE → tx 0xEE; key and pt unchanged.
- TIMEOUT=100; 0x02 plus 5 bytes, then silence → 0xEE sent about 100 cycles after the last byte; the next 0x02 frame loads correctly.
- rx_error asserted during LOAD_PT → exactly one rx_ack pulse, tx 0xEE, FSM back in IDLE.
- Back-to-back rx_avail with rx_ack feedback modelled as in the UART → every byte is taken exactly once. tx_wr never asserts while tx_busy is high or in consecutive cycles.
